// File: rtl/expand_tokens.sv
// expand_tokens: each accepted input token credits FACTOR output tokens; b emits one per cycle until the backlog drains.
// Latency: first b one cycle after the accepting a. Optional ready/drop behaviour under EXPAND_TOKENS_BACKPRESSURE_EN.
// Without backpressure every a is accepted and excess credits saturate at MAX_PENDING, setting the sticky overflow.
module expand_tokens #(
    parameter int FACTOR      = 2,
    parameter int MAX_PENDING = 15,
    localparam int CW         = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a,
    input  logic          clr_ovf,
    output logic          b,
    output logic [CW-1:0] pending,
    output logic          overflow,
    output logic          idle
`ifdef EXPAND_TOKENS_BACKPRESSURE_EN
    ,
    output logic          ready
`endif
);

    localparam int AW = CW + 4;
    localparam logic [AW-1:0] FACTOR_W = AW'(FACTOR);
    localparam logic [AW-1:0] MAX_W    = AW'(MAX_PENDING);
    localparam logic [CW-1:0] MAX_P    = CW'(MAX_PENDING);

    logic          accepted;
    logic          dropped;
    logic          emit;
    logic          sat;
    logic [AW-1:0] total;
    logic [AW-1:0] next_p;

`ifdef EXPAND_TOKENS_BACKPRESSURE_EN
    // Accept only when a full FACTOR credit fits after this cycle's drain.
    assign ready = ({4'b0000, pending} + FACTOR_W - AW'(1)) <= MAX_W;
`endif

    always_comb begin
        accepted = a;
        dropped  = 1'b0;
`ifdef EXPAND_TOKENS_BACKPRESSURE_EN
        accepted = a && ready;
        dropped  = a && !ready;
`endif
        total  = {4'b0000, pending} + (accepted ? FACTOR_W : '0);
        emit   = (total != '0);
        next_p = total - {{(AW-1){1'b0}}, emit};
        sat    = next_p > MAX_W;
    end

    assign idle = (pending == '0) && !b;

    always_ff @(posedge clk) begin
        if (!rst) begin
            b        <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            b       <= emit;
            pending <= sat ? MAX_P : CW'(next_p);
            // A new loss in the same cycle as a clear keeps the flag set.
            if (sat || dropped)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_expand_tokens.sv
// Bench for expand_tokens with FACTOR=2, MAX_PENDING=7: directed scenarios then random traffic vs a credit-count model.
module tb_expand_tokens;

    localparam int F   = 2;
    localparam int MAX = 7;
    localparam int CW  = $clog2(MAX + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          a;
    logic          clr_ovf;
    logic          b;
    logic [CW-1:0] pending;
    logic          overflow;
    logic          idle;
`ifdef EXPAND_TOKENS_BACKPRESSURE_EN
    logic          ready;
`endif

    expand_tokens #(.FACTOR(F), .MAX_PENDING(MAX)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .clr_ovf  (clr_ovf),
        .b        (b),
        .pending  (pending),
        .overflow (overflow),
        .idle     (idle)
`ifdef EXPAND_TOKENS_BACKPRESSURE_EN
        ,
        .ready    (ready)
`endif
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: owed output tokens as a plain integer.
    int m_p   = 0;
    int m_b   = 0;
    int m_ovf = 0;
    int acc_cnt  = 0;
    int lost_cnt = 0;
    int b_cnt    = 0;
    bit bp_build = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_ready();
        return (m_p + F - 1 <= MAX) ? 1 : 0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".b"}, int'(b), m_b);
        check({tag, ".pending"}, int'(pending), m_p);
        check({tag, ".overflow"}, int'(overflow), m_ovf);
        check({tag, ".idle"}, int'(idle), (m_p == 0 && m_b == 0) ? 1 : 0);
`ifdef EXPAND_TOKENS_BACKPRESSURE_EN
        check({tag, ".ready"}, int'(ready), model_ready());
`endif
    endtask

    // Apply one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input string tag, input logic a_in, input logic clr_in, input logic rst_in);
        int acc, drop, tot, nxt;
        a       = a_in;
        clr_ovf = clr_in;
        rst     = rst_in;
        if (!rst_in) begin
            m_p = 0; m_b = 0; m_ovf = 0;
        end else begin
            acc  = (a_in && (!bp_build || model_ready() == 1)) ? 1 : 0;
            drop = (a_in && !acc) ? 1 : 0;
            tot  = m_p + (acc ? F : 0);
            m_b  = (tot > 0) ? 1 : 0;
            nxt  = tot - m_b;
            acc_cnt += acc;
            if (nxt > MAX) begin
                lost_cnt += nxt - MAX;
                nxt = MAX;
                m_ovf = 1;
            end else if (drop) begin
                m_ovf = 1;
            end else if (clr_in) begin
                m_ovf = 0;
            end
            m_p = nxt;
        end
        @(posedge clk);
        #1;
        if (b === 1'b1) b_cnt++;
        check_all(tag);
    endtask

    initial begin
`ifdef EXPAND_TOKENS_BACKPRESSURE_EN
        bp_build = 1'b1;
`endif
        a = 1'b0; clr_ovf = 1'b0; rst = 1'b0;
        #2;
        step("reset", 1'b0, 1'b0, 1'b0);
        step("reset2", 1'b0, 1'b0, 1'b0);
        check("reset.idle_const", int'(idle), 1);

        // Single pulse: b high for two cycles, then idle.
        step("single0", 1'b1, 1'b0, 1'b1);
        check("single0.b_const", int'(b), 1);
        check("single0.p_const", int'(pending), 1);
        step("single1", 1'b0, 1'b0, 1'b1);
        check("single1.p_const", int'(pending), 0);
        step("single2", 1'b0, 1'b0, 1'b1);
        check("single2.b_const", int'(b), 0);
        check("single2.idle_const", int'(idle), 1);

        // Two pulses then drain: pending 1,2,1,0,0.
        step("pat0", 1'b1, 1'b0, 1'b1);
        step("pat1", 1'b1, 1'b0, 1'b1);
        check("pat1.p_const", int'(pending), 2);
        for (int i = 0; i < 4; i++) step("pat_drain", 1'b0, 1'b0, 1'b1);
        check("pat.b_end_const", int'(b), 0);

        // Hold a until saturation (or backpressure drop), then exercise the clear.
        for (int i = 0; i < 8; i++) step("sat", 1'b1, 1'b0, 1'b1);
        check("sat.overflow_const", int'(overflow), 1);
        check("sat.b_const", int'(b), 1);
        step("sat_clr_tie", 1'b1, 1'b1, 1'b1);
        check("sat_clr_tie.overflow_const", int'(overflow), 1);
        step("sat_clr", 1'b0, 1'b1, 1'b1);
        step("sat_hold", 1'b0, 1'b0, 1'b1);

        // Reset mid-backlog discards all credits.
        step("rst_prep_rst", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("rst_prep", 1'b1, 1'b0, 1'b1);
        check("rst_prep.p_const", int'(pending), 5);
        step("rst_mid", 1'b0, 1'b0, 1'b0);
        check("rst_mid.b_const", int'(b), 0);
        check("rst_mid.p_const", int'(pending), 0);
        for (int i = 0; i < 4; i++) step("rst_after", 1'b0, 1'b0, 1'b1);

        // Random traffic with conservation accounting.
        acc_cnt = 0; lost_cnt = 0; b_cnt = 0;
        for (int i = 0; i < 1000; i++)
            step("rand", ($urandom_range(99) < 40) ? 1'b1 : 1'b0,
                 ($urandom_range(99) < 5) ? 1'b1 : 1'b0, 1'b1);
        begin
            int budget;
            budget = 0;
            while (idle !== 1'b1 && budget < 40) begin
                step("drain", 1'b0, 1'b0, 1'b1);
                budget++;
            end
            check("drain.idle_reached", int'(idle), 1);
        end
        check("conservation", b_cnt, F * acc_cnt - lost_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/expand_tokens.md
# expand_tokens

Serial token expander: every cycle with `a` high credits FACTOR output tokens to a backlog, and `b` emits at most one token per cycle until the backlog drains. This block is the inverse of the token-halving stage. It restores token density on the far side of a rate-reducing path, and it reports backlog depth and loss.

## Interface
Parameters:
- FACTOR, 2, output tokens credited per input token; legal range 1..8.
- MAX_PENDING, 15, backlog capacity in tokens; must be >= FACTOR.
- Derived CW = $clog2(MAX_PENDING+1), the width of the backlog counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset (asserted when 0).
- a  input  1  input token; a 1 in a cycle means one token.
- clr_ovf  input  1  clears the sticky overflow flag.
- b  output  1  output token, registered.
- pending  output  CW  current backlog P, registered.
- overflow  output  1  sticky flag; set when credits are lost.
- idle  output  1  combinational: (P == 0) && !b.
- ready  output  1  present only when EXPAND_TOKENS_BACKPRESSURE_EN is defined (see Configuration).

## Operation
- State: backlog register P (CW bits), output register b, and register overflow. There is no FSM beyond the counter.
- Arithmetic each cycle, performed at width CW+4 with no truncation:
  - accepted = a, or a && ready when backpressure is compiled in.
  - total = P + (accepted ? FACTOR : 0).
  - emit = (total != 0).
  - next = total - emit.
- Update when rst==1:
  - b <= emit.
  - If next > MAX_PENDING, then P <= MAX_PENDING and overflow <= 1 (saturate). Otherwise P <= next.
- Overflow is cleared when clr_ovf==1, and only if no new overflow occurs in the same cycle. On a tie, set wins over clear.
- Dropped input (backpressure build only): a==1 with ready==0 is discarded and sets overflow. P is unchanged apart from its normal drain.
- Token conservation, with no overflow: total b pulses = FACTOR × total accepted a pulses.

## Timing
- Reset (rst==0 at posedge):
  - b=0, P=0, overflow=0, idle=1.
  - Reset applies mid-backlog: all pending credits are discarded and no further b pulses are produced.
- Latency: first b pulse appears one cycle after the accepting a cycle.
- Throughput: at most one b per cycle. The backlog drains by 1 per cycle when no input arrives.
- Continuous a with FACTOR>=2: P grows by FACTOR-1 per cycle until saturation. b stays high throughout.
- FACTOR==1: b is a one-cycle-delayed copy of a. P stays 0 and overflow never sets.
- Boundaries:
  - P==0 with a==0 gives b<=0.
  - P==MAX_PENDING with a==1 overflows (no-backpressure build).
  - A 1→0 transition on a leaves exactly P more b pulses after the current one.

## Configuration
- EXPAND_TOKENS_BACKPRESSURE_EN defined:
  - Output ready = (P + FACTOR - 1 <= MAX_PENDING), decoded combinationally from registered P.
  - Accepted tokens can never saturate P.
  - overflow sets only on a==1 while ready==0.
- EXPAND_TOKENS_BACKPRESSURE_EN undefined:
  - No ready port.
  - Every a==1 is accepted.
  - Excess credits are lost by saturation at MAX_PENDING, which sets overflow.

## Test plan
All scenarios use FACTOR=2, MAX_PENDING=7.
- Single pulse: a=1 at cycle 0, then 0 → b=1 at cycles 1 and 2, 0 from cycle 3; pending 1,0; idle=1 from cycle 3.
- Pattern a=1,1,0,0,0,0 → b=1 on cycles 1–4, 0 on cycle 5; pending after each edge = 1,2,1,0,0.
- Saturation (no backpressure): a=1 for 8 cycles → pending reaches 7 after 7 cycles; 8th cycle keeps pending=7 and overflow=1; overflow stays 1 until clr_ovf=1, and clr_ovf with a=1 at pending=7 leaves overflow=1.
- Backpressure build: a=1 held → ready drops when pending=7 (7+1 > 7); next a=1 dropped → pending=6, overflow=1, b stays 1.
- Reset mid-operation: pending=5, rst=0 for one cycle → next cycle b=0, pending=0, overflow=0; no residual b pulses afterwards.
- Conservation: random a for 1000 cycles, then idle until idle=1 → count(b) == 2·count(a) whenever overflow==0.
